if_stage: RTL and testbench

//   Instruction-fetch stage and IF/ID pipeline register feeding the decode controller.
//   - Owns the PC.
//   - Addresses the combinational IROM.
//   - Registers {pc, pc+4, inst, valid} into ID each cycle.
//   - Honours stall from the hazard unit and flush/redirect from EX (taken branch, jal, jalr).
//   - Squashed slots carry inst=32'h0; the decoder reports a zero word as no instruction.

---
 rtl/if_stage.sv | 147 ++++++++++++++
 tb/tb_if_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the IROM and drives the IF/ID register.
// Optional performance counters are built only when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IROM_AW     = 14,
  parameter int unsigned BOOT_CYCLES = 1
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic [31:0]        redirect_pc,
  output logic [IROM_AW-1:0] irom_addr,
  input  logic [31:0]        irom_inst,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  output logic [31:0]        id_inst,
  output logic               id_valid,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt,
  output logic [31:0]        perf_stall_cnt
);

  localparam int unsigned BootW = 4;
  localparam int unsigned PcW   = 32;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [BootW-1:0]   boot_cnt_q, boot_cnt_d;
  logic [PcW-1:0]     pc_q, pc_d;
  logic [PcW-1:0]     id_pc_q, id_pc_d;
  logic [PcW-1:0]     id_pc4_q, id_pc4_d;
  logic [PcW-1:0]     id_inst_q, id_inst_d;
  logic               id_valid_q, id_valid_d;
  logic               adv_c, flush_ev_c, stall_ev_c;
  logic [1:0]         unused_redirect_lsb;

  // Redirect targets are word-aligned by force; the dropped bits are intentionally ignored.
  assign unused_redirect_lsb = redirect_pc[1:0];

  assign irom_addr = pc_q[IROM_AW+1:2];

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  // Next-state: BOOT inserts bubbles; RUN resolves flush > stall > advance.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    adv_c      = 1'b0;
    flush_ev_c = 1'b0;
    stall_ev_c = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        id_pc_d    = '0;
        id_pc4_d   = '0;
        id_inst_d  = '0;
        id_valid_d = 1'b0;
        boot_cnt_d = boot_cnt_q + BootW'(1);
        if (boot_cnt_q == BootW'(BOOT_CYCLES - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          flush_ev_c = 1'b1;
          pc_d       = {redirect_pc[31:2], 2'b00};
          id_pc_d    = '0;
          id_pc4_d   = '0;
          id_inst_d  = '0;
          id_valid_d = 1'b0;
        end else if (stall) begin
          stall_ev_c = 1'b1;
        end else begin
          adv_c      = 1'b1;
          id_pc_d    = pc_q;
          id_pc4_d   = pc_q + PcW'(4);
          id_inst_d  = irom_inst;
          id_valid_d = 1'b1;
          pc_d       = pc_q + PcW'(4);
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign id_pc    = id_pc_q;
  assign id_pc4   = id_pc4_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q, stall_cnt_q;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (adv_c)      fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (flush_ev_c) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (stall_ev_c) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  logic unused_perf_ev;

  assign unused_perf_ev = adv_c ^ flush_ev_c ^ stall_ev_c;
  assign perf_fetch_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized stall/flush traffic
// compared against a cycle-level behavioural model of the fetch stage.
module tb_if_stage;

  localparam int unsigned AW        = 14;
  localparam int unsigned BOOT      = 1;
  localparam logic [31:0] RST_PC    = 32'h0000_0000;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst_n;
  logic          stall;
  logic          flush;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] irom_addr;
  logic [31:0]   irom_inst;
  logic [31:0]   id_pc, id_pc4, id_inst;
  logic          id_valid;
  logic [31:0]   perf_fetch_cnt, perf_flush_cnt, perf_stall_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_inst;
  logic        m_id_valid;
  bit          m_run;
  int          m_boot_done;
  logic [31:0] m_fetch, m_flush, m_stall;

  always #5 cpu_clk = ~cpu_clk;

  if_stage #(
    .RESET_PC    (RST_PC),
    .IROM_AW     (AW),
    .BOOT_CYCLES (BOOT)
  ) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst_n      (cpu_rst_n),
    .stall          (stall),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .irom_addr      (irom_addr),
    .irom_inst      (irom_inst),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4),
    .id_inst        (id_inst),
    .id_valid       (id_valid),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  // IROM image: word n = 0x13 + (n << 20)
  assign irom_inst = 32'h0000_0013 + (32'(irom_addr) << 20);

  function automatic logic [31:0] rom_word(input logic [31:0] byte_addr);
    int unsigned n;
    n = (byte_addr / 4) % (1 << AW);
    return 32'h0000_0013 + (32'(n) << 20);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_id_pc = 0; m_id_pc4 = 0; m_id_inst = 0; m_id_valid = 0;
    m_run = 0; m_boot_done = 0;
    m_fetch = 0; m_flush = 0; m_stall = 0;
  endtask

  task automatic model_bubble();
    m_id_pc = 0; m_id_pc4 = 0; m_id_inst = 0; m_id_valid = 0;
  endtask

  task automatic model_edge(input logic st, input logic fl, input logic [31:0] rd);
    if (!m_run) begin
      model_bubble();
      m_boot_done++;
      if (m_boot_done >= BOOT) m_run = 1;
    end else if (fl) begin
      m_pc = (rd / 4) * 4;
      model_bubble();
      m_flush++;
    end else if (st) begin
      m_stall++;
    end else begin
      m_id_pc    = m_pc;
      m_id_pc4   = m_pc + 4;
      m_id_inst  = rom_word(m_pc);
      m_id_valid = 1;
      m_pc       = m_pc + 4;
      m_fetch++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".id_pc"},    id_pc,             m_id_pc);
    chk({tag, ".id_pc4"},   id_pc4,            m_id_pc4);
    chk({tag, ".id_inst"},  id_inst,           m_id_inst);
    chk({tag, ".id_valid"}, 32'(id_valid),     32'(m_id_valid));
    chk({tag, ".irom_adr"}, 32'(irom_addr),    (m_pc / 4) % (1 << AW));
`ifdef IF_PERF_CNT_EN
    chk({tag, ".p_fetch"},  perf_fetch_cnt,    m_fetch);
    chk({tag, ".p_flush"},  perf_flush_cnt,    m_flush);
    chk({tag, ".p_stall"},  perf_stall_cnt,    m_stall);
`else
    chk({tag, ".p_fetch"},  perf_fetch_cnt,    32'h0);
    chk({tag, ".p_flush"},  perf_flush_cnt,    32'h0);
    chk({tag, ".p_stall"},  perf_stall_cnt,    32'h0);
`endif
  endtask

  task automatic step(input string tag, input logic st, input logic fl, input logic [31:0] rd);
    stall = st; flush = fl; redirect_pc = rd;
    @(posedge cpu_clk);
    model_edge(st, fl, rd);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] rd;
    logic        st, fl;

    cpu_rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge cpu_clk);
    #1;
    model_reset();
    check_all("reset");
    @(negedge cpu_rst_n or negedge cpu_clk);
    cpu_rst_n = 1'b1;

    // Sequential fetch after boot
    step("t1_boot", 0, 0, 0);
    chk("t1_boot_valid", 32'(id_valid), 32'h0);
    step("t1_f0", 0, 0, 0);
    chk("t1_pc0_inst", id_inst, 32'h0000_0013);
    step("t1_f1", 0, 0, 0);
    chk("t1_pc4_inst", id_inst, 32'h0010_0013);
    step("t1_f2", 0, 0, 0);
    chk("t1_pc8", id_pc, 32'h8);

    // Stall holds ID at pc 8
    repeat (3) step("t2_stall", 1, 0, 0);
    chk("t2_hold_pc", id_pc, 32'h8);
    step("t2_rel", 0, 0, 0);
    chk("t2_pc12", id_pc, 32'hC);
    step("t2_pc16", 0, 0, 0);

    // Flush with misaligned redirect
    step("t3_flush", 0, 1, 32'h0000_0103);
    chk("t3_bubble_inst", id_inst, 32'h0);
    step("t3_target", 0, 0, 0);
    chk("t3_pc100", id_pc, 32'h100);

    // Flush beats stall
    step("t4_both", 1, 1, 32'h40);
    step("t4_target", 0, 0, 0);
    chk("t4_pc40", id_pc, 32'h40);

    // PC wrap at the top of the address space
    step("wrap_flush", 0, 1, 32'hFFFF_FFFE);
    step("wrap_top", 0, 0, 0);
    chk("wrap_pc4", id_pc4, 32'h0);
    step("wrap_zero", 0, 0, 0);
    chk("wrap_pc0", id_pc, 32'h0);

    // Async reset pulse inside one clock period
    #1 cpu_rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t5_async");
    #1 cpu_rst_n = 1'b1;

    // Counter scenario: boot, 10 advance, 2 stall, 1 flush
    step("t6_boot", 0, 0, 0);
    repeat (10) step("t6_adv", 0, 0, 0);
    repeat (2) step("t6_stall", 1, 0, 0);
    step("t6_flush", 0, 1, 32'h200);
`ifdef IF_PERF_CNT_EN
    chk("t6_fetch10", perf_fetch_cnt, 32'd10);
    chk("t6_stall2",  perf_stall_cnt, 32'd2);
    chk("t6_flush1",  perf_flush_cnt, 32'd1);
`else
    chk("t6_fetch0",  perf_fetch_cnt, 32'd0);
    chk("t6_stall0",  perf_stall_cnt, 32'd0);
    chk("t6_flush0",  perf_flush_cnt, 32'd0);
`endif

    // Randomized stall/flush traffic
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : 32'($urandom);
      step("rand", st, fl, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
